conf_cmd_ctrl: RTL
==================

Name: conf_cmd_ctrl

Overview:
- Command/frame controller sitting directly upstream of the configuration register bank (REGS_CONF).
- Consumes bytes from the UART receiver and parses write/read commands.
- Generates the bank's strobes: shift_rxregs, load_confregs, load_txregs, shift_txregs.
- Paces readback through the UART transmitter, which takes its data from the bank's txdw.

Parameters:
N_BYTES, 11, payload bytes per frame (control 1 + frec_mod 3 + frec_por 3 + im_am 2 + im_fm 2)
CMD_WR, 8'h57, opcode for write frame ('W')
CMD_RD, 8'h52, opcode for readback ('R')
TIMEOUT, 100000, max clk cycles between payload bytes of a write frame

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-low reset
rx_data  in  8  byte from UART receiver
rx_valid  in  1  one-cycle pulse, rx_data valid
tx_busy  in  1  UART transmitter busy
rxdw  out  8  registered byte to bank serial input
shift_rxregs  out  1  one-cycle strobe, shift rxdw into bank
load_confregs  out  1  one-cycle strobe, commit shifted frame to config regs
load_txregs  out  1  one-cycle strobe, copy config regs into tx shift chain
shift_txregs  out  1  one-cycle strobe, advance tx chain to next byte
tx_start  out  1  one-cycle strobe, UART transmits current txdw
busy  out  1  high whenever state != IDLE
cmd_err  out  1  one-cycle pulse on bad opcode or write timeout

Behaviour:
- Reset (rst=0, asynchronous): state IDLE, all outputs 0, rxdw=0, counters 0. Reset mid-frame aborts with no further strobes; a partial write never produces load_confregs.
- All outputs are registered. Strobes are exactly one cycle wide.
- States: IDLE, WR_DATA, WR_COMMIT, RD_LOAD, RD_SEND, RD_WAIT, RD_SHIFT.
- IDLE, on rx_valid:
  - rx_data==CMD_WR -> WR_DATA, byte_cnt=0, timer=0.
  - rx_data==CMD_RD -> RD_LOAD.
  - Any other value -> cmd_err pulse next cycle, remain IDLE.
- WR_DATA:
  - On rx_valid, the next cycle has rxdw=rx_data and shift_rxregs=1 coincident (latency 1 clk).
  - Each accepted byte increments byte_cnt and clears timer.
  - After byte N_BYTES-1 is accepted -> WR_COMMIT.
  - With no rx_valid, timer increments. At timer==TIMEOUT-1 -> cmd_err pulse, IDLE, no load_confregs; bank config outputs unchanged.
  - If rx_valid arrives in the same cycle as expiry, the byte wins and the timer clears.
- WR_COMMIT: load_confregs=1 for one cycle, exactly one cycle after the last shift_rxregs, then IDLE.
- RD_LOAD: load_txregs=1 for one cycle, byte_cnt=0 -> RD_SEND.
- RD_SEND: wait for tx_busy==0, then tx_start=1 for one cycle -> RD_WAIT.
- RD_WAIT: wait for tx_busy to be seen high and subsequently low (a rising-then-falling sequence). Tolerates busy asserting 1+ cycles after tx_start -> RD_SHIFT.
- RD_SHIFT: shift_txregs=1 for one cycle, byte_cnt++. If byte_cnt was N_BYTES-1 -> IDLE, else -> RD_SEND.
- Readback order equals write order: control byte first, then MSB-first per field.
- rx_valid in WR_COMMIT and all RD_* states is ignored; the byte is dropped with no error.
- Widths:
  - byte_cnt is clog2(N_BYTES) bits.
  - timer is clog2(TIMEOUT) bits and saturates; no wrap.
  - busy is combinational from the state register.

Decomposition:
- Package conf_pkg holds:
  - N_BYTES, CMD_WR, CMD_RD constants;
  - the state enum typedef;
  - field byte offsets (CTRL=0, FMOD=1, FPOR=4, IMAM=7, IMFM=9), shared with REGS_CONF and benches.
- One sub-module, gap_timer: clear/enable/expired counter, parameterised by TIMEOUT. Everything else lives in one FSM.

Test Plan:
- Write frame: rx 0x57 then bytes 0x01..0x0B (bench TIMEOUT=50) -> 11 shift_rxregs with rxdw=0x01..0x0B in order, one load_confregs one cycle after the last. Attached bank shows r_control=0x01, r_frec_mod=0x020304, r_frec_por=0x050607, r_im_am=0x0809, r_im_fm=0x0A0B. cmd_err stays 0.
- Readback after the above, UART model busy 10 cycles starting 1 cycle after tx_start -> 1 load_txregs, then 11 tx_start/shift_txregs pairs. txdw sampled at each tx_start equals 0x01..0x0B. busy falls after the 11th shift.
- Bad opcode 0x41 in IDLE -> single cmd_err pulse, no other strobe, busy stays 0.
- Timeout: 0x57 + 5 bytes, then silence for 50 cycles -> cmd_err, no load_confregs, config unchanged. A following full write succeeds normally.
- Expiry race: byte delivered exactly on the cycle timer==TIMEOUT-1 -> accepted, shift_rxregs issued, no cmd_err.
- Reset mid-read: rst low after the 4th shift_txregs -> all strobes 0 and busy 0 immediately. A subsequent 0x52 returns all 11 bytes starting at 0x01.

Source files
------------

// File: rtl/conf_pkg.sv
// Shared constants, state encoding and frame layout for the config command path.
// Frame: control(1) frec_mod(3) frec_por(3) im_am(2) im_fm(2), fields MSB first.
package conf_pkg;

  localparam int N_BYTES = 11;
  localparam int CNT_W   = $clog2(N_BYTES);

  localparam logic [7:0] CMD_WR = 8'h57;
  localparam logic [7:0] CMD_RD = 8'h52;

  localparam int OFS_CTRL = 0;
  localparam int OFS_FMOD = 1;
  localparam int OFS_FPOR = 4;
  localparam int OFS_IMAM = 7;
  localparam int OFS_IMFM = 9;

  typedef enum logic [2:0] {
    IDLE,
    WR_DATA,
    WR_COMMIT,
    RD_LOAD,
    RD_SEND,
    RD_WAIT,
    RD_SHIFT
  } state_t;

endpackage

// File: rtl/conf_cmd_ctrl_gap_timer.sv
// Inter-byte gap counter: clr zeroes, en counts up and saturates at TIMEOUT-1.
// Ports: clk, rst (async low), clr, en in; expired out (en && count==TIMEOUT-1).
module gap_timer #(
  parameter int TIMEOUT = 100000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [W-1:0] LAST = W'(TIMEOUT - 1);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && cnt != LAST) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign expired = en && (cnt == LAST);

endmodule

// File: rtl/conf_cmd_ctrl.sv
// Command/frame controller in front of the config register bank.
// Ports: clk, rst, rx_data/rx_valid, tx_busy in; bank strobes, rxdw, tx_start, busy, cmd_err out.
module conf_cmd_ctrl
  import conf_pkg::*;
#(
  parameter int TIMEOUT = 100000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  input  logic       tx_busy,
  output logic [7:0] rxdw,
  output logic       shift_rxregs,
  output logic       load_confregs,
  output logic       load_txregs,
  output logic       shift_txregs,
  output logic       tx_start,
  output logic       busy,
  output logic       cmd_err
);

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(N_BYTES - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             seen_q, seen_d;
  logic             expired;

  logic [7:0] rxdw_d;
  logic       shift_rx_d;
  logic       load_conf_d;
  logic       load_tx_d;
  logic       shift_tx_d;
  logic       tx_start_d;
  logic       cmd_err_d;

  gap_timer #(
    .TIMEOUT(TIMEOUT)
  ) u_gap (
    .clk    (clk),
    .rst    (rst),
    .clr    ((state_q != WR_DATA) || rx_valid),
    .en     (state_q == WR_DATA),
    .expired(expired)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      seen_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      seen_q  <= seen_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    seen_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (rx_valid) begin
          if (rx_data == CMD_WR) begin
            state_d = WR_DATA;
            cnt_d   = '0;
          end else if (rx_data == CMD_RD) begin
            state_d = RD_LOAD;
          end
        end
      end
      WR_DATA: begin
        // a byte arriving on the expiry cycle takes priority
        if (rx_valid) begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == LAST_IDX) state_d = WR_COMMIT;
        end else if (expired) begin
          state_d = IDLE;
        end
      end
      WR_COMMIT: state_d = IDLE;
      RD_LOAD: begin
        cnt_d   = '0;
        state_d = RD_SEND;
      end
      RD_SEND: begin
        if (!tx_busy) state_d = RD_WAIT;
      end
      RD_WAIT: begin
        // busy may rise a few cycles after tx_start; wait for high then low
        seen_d = seen_q | tx_busy;
        if (seen_q && !tx_busy) state_d = RD_SHIFT;
      end
      RD_SHIFT: begin
        cnt_d   = cnt_q + 1'b1;
        state_d = (cnt_q == LAST_IDX) ? IDLE : RD_SEND;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    shift_rx_d  = (state_q == WR_DATA) && rx_valid;
    rxdw_d      = shift_rx_d ? rx_data : rxdw;
    load_conf_d = (state_q == WR_COMMIT);
    load_tx_d   = (state_q == RD_LOAD);
    tx_start_d  = (state_q == RD_SEND) && !tx_busy;
    shift_tx_d  = (state_q == RD_SHIFT);
    cmd_err_d   = ((state_q == IDLE) && rx_valid &&
                   (rx_data != CMD_WR) && (rx_data != CMD_RD)) ||
                  ((state_q == WR_DATA) && !rx_valid && expired);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rxdw          <= '0;
      shift_rxregs  <= 1'b0;
      load_confregs <= 1'b0;
      load_txregs   <= 1'b0;
      shift_txregs  <= 1'b0;
      tx_start      <= 1'b0;
      cmd_err       <= 1'b0;
    end else begin
      rxdw          <= rxdw_d;
      shift_rxregs  <= shift_rx_d;
      load_confregs <= load_conf_d;
      load_txregs   <= load_tx_d;
      shift_txregs  <= shift_tx_d;
      tx_start      <= tx_start_d;
      cmd_err       <= cmd_err_d;
    end
  end

  assign busy = (state_q != IDLE);

endmodule
